fifo_sync: RTL and testbench
============================

FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 Parameter: WIDTH, default 6, data word width in bits.
REQ-002 Parameter: DEPTH, default 8, number of storage entries; power of two, minimum 2.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 Port: WE  input  1  write enable; data_in is accepted on the rising edge when WE=1 and a write is permitted.
REQ-006 Port: RE  input  1  read enable; one word is popped on the rising edge when RE=1 and empty=0.
REQ-007 Port: data_in  input  WIDTH  write data.
REQ-008 Port: data_out  output  WIDTH  registered read data.
REQ-009 Port: empty  output  1  high when occupancy is 0.
REQ-010 Port: full  output  1  high when occupancy equals DEPTH.

Function
REQ-011 Storage SHALL be DEPTH x WIDTH registers, with write pointer, read pointer and occupancy count.
- Pointer width: log2(DEPTH).
- Count width: log2(DEPTH)+1.
REQ-012 Pointers SHALL wrap modulo DEPTH (entry DEPTH-1 -> entry 0) with no data loss.
REQ-013 Accepted write:
- mem[wptr] <= data_in.
- wptr increments.
REQ-014 Accepted read:
- data_out <= mem[rptr] on the same edge, so data is valid the cycle after RE.
- rptr increments.
REQ-015 With no accepted read, data_out SHALL hold its last value, including reads attempted while empty.
REQ-016 A write while full and RE=0 SHALL be dropped: no pointer, count or memory change.
REQ-017 A read while empty SHALL be ignored, including when WE=1 on the same edge; the write proceeds and count becomes 1.
REQ-018 Simultaneous WE=1 and RE=1 with 0 < count < DEPTH: both occur, count is unchanged.
REQ-019 Simultaneous WE=1 and RE=1 while full: the read pops the oldest word and the write is accepted into the freed slot; count stays DEPTH and full stays 1.
REQ-020 Count update per edge: +1 on write only, -1 on read only, unchanged otherwise.
REQ-021 empty and full SHALL be decoded combinationally from count and never be high together.
REQ-022 Ordering SHALL be strictly first-in first-out.

Reset
REQ-023 When reset=0, asynchronously and regardless of clk:
- wptr = 0, rptr = 0, count = 0.
- data_out = 0.
- empty = 1, full = 0.
REQ-024 Memory contents need not be cleared on reset.
REQ-025 Reset asserted mid-operation discards all stored words; the first read after release returns the first word written after release.
REQ-026 WE and RE SHALL have no effect while reset=0.

Verification
REQ-027 Reset: pulse reset low, then release -> empty=1, full=0, data_out=0x00.
REQ-028 Basic order:
- Stimulus: write 0x20, 0x02, 0x34, 0x0F, then 4 reads.
- Response: data_out = 0x20, 0x02, 0x34, 0x0F on successive cycles; empty=1 after the last read.
REQ-029 Full and overflow:
- Stimulus: write 0x10..0x17 (8 words), then write 0x3F.
- Response: full=1 after the 8th write; 0x3F is dropped; 8 reads return 0x10..0x17.
REQ-030 Simultaneous at full:
- Stimulus: FIFO holds 0x10..0x17; one cycle with WE=1, RE=1, data_in=0x18.
- Response: data_out=0x10, full remains 1; the following reads return 0x11..0x18.
REQ-031 Wrap and underflow:
- Stimulus: run 20 words through with interleaved reads and writes; issue RE while empty.
- Response: all data matches in order; on the empty read data_out holds its value and empty stays 1.
REQ-032 Mid-operation reset:
- Stimulus: hold 3 words, assert reset asynchronously between clock edges.
- Response: empty=1 and data_out=0 immediately; after release, write 0x05 and read -> data_out=0x05.

Source files
------------

// File: rtl/fifo_sync.sv
// Single-clock first-in first-out buffer with registered read data and
// occupancy-derived empty/full flags.
module fifo_sync #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             WE,
    input  logic             RE,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             wr_en, rd_en;

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == CW'(DEPTH));
        rd_en = RE && !empty;
        // When full, a concurrent read frees the slot the write lands in.
        wr_en = WE && (!full || rd_en);

        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;

        if (wr_en) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (rd_en) begin
            rptr_d     = rptr_q + PW'(1);
            data_out_d = mem[rptr_q];
        end

        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            data_out_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage is not cleared; gating on reset keeps writes inert while held.
    always_ff @(posedge clk) begin
        if (wr_en && reset) begin
            mem[wptr_q] <= data_in;
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync: reset, ordering, overflow, full-simultaneous,
// wrap/underflow and asynchronous mid-operation reset.
module tb_fifo_sync;

    logic       clk;
    logic       reset;
    logic       WE;
    logic       RE;
    logic [5:0] data_in;
    logic [5:0] data_out;
    logic       empty;
    logic       full;

    int errors = 0;
    int checks = 0;

    fifo_sync #(.WIDTH(6), .DEPTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .WE       (WE),
        .RE       (RE),
        .data_in  (data_in),
        .data_out (data_out),
        .empty    (empty),
        .full     (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [5:0] v);
        WE = 1'b1; RE = 1'b0; data_in = v;
        tick();
        WE = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [5:0] v);
        WE = 1'b0; RE = 1'b1;
        tick();
        RE = 1'b0;
        check(tag, {2'b0, data_out}, {2'b0, v});
        $display("read  %s data_out=0x%02h", tag, data_out);
    endtask

    logic [5:0] exp_q[$];
    logic [5:0] basic_v[4];
    logic [5:0] last_v;
    logic [5:0] w;
    int         wr_idx;

    initial begin
        reset = 1'b0; WE = 1'b0; RE = 1'b0; data_in = '0;
        basic_v[0] = 6'h20; basic_v[1] = 6'h02; basic_v[2] = 6'h34; basic_v[3] = 6'h0F;

        // Reset held, with enables active to confirm they are ignored
        tick();
        WE = 1'b1; RE = 1'b1; data_in = 6'h3C;
        tick();
        check("rst_empty", {7'b0, empty}, 8'h01);
        check("rst_full", {7'b0, full}, 8'h00);
        check("rst_dout", {2'b0, data_out}, 8'h00);
        WE = 1'b0; RE = 1'b0;
        reset = 1'b1;
        tick();
        check("rel_empty", {7'b0, empty}, 8'h01);
        check("rel_dout", {2'b0, data_out}, 8'h00);
        $display("reset released empty=%0b full=%0b data_out=0x%02h", empty, full, data_out);

        // Basic order
        for (int i = 0; i < 4; i++) begin
            push(basic_v[i]);
            $display("write basic 0x%02h", basic_v[i]);
        end
        check("basic_not_empty", {7'b0, empty}, 8'h00);
        for (int i = 0; i < 4; i++) pop_check($sformatf("basic%0d", i), basic_v[i]);
        check("basic_empty_end", {7'b0, empty}, 8'h01);

        // Fill to full, then overflow
        for (int i = 0; i < 8; i++) begin
            push(6'(8'h10 + i));
            $display("write fill 0x%02h full=%0b", 6'(8'h10 + i), full);
            if (i == 6) check("full_at7", {7'b0, full}, 8'h00);
        end
        check("full_at8", {7'b0, full}, 8'h01);
        check("full_not_empty", {7'b0, empty}, 8'h00);
        push(6'h3F);
        $display("write overflow 0x3F full=%0b", full);
        check("ovf_full", {7'b0, full}, 8'h01);

        // Simultaneous read and write while full
        WE = 1'b1; RE = 1'b1; data_in = 6'h18;
        tick();
        WE = 1'b0; RE = 1'b0;
        $display("rdwr at full data_out=0x%02h full=%0b", data_out, full);
        check("simfull_dout", {2'b0, data_out}, 8'h10);
        check("simfull_full", {7'b0, full}, 8'h01);
        for (int i = 1; i <= 8; i++) pop_check($sformatf("after_sim%0d", i), 6'(8'h10 + i));
        check("drain_empty", {7'b0, empty}, 8'h01);

        // Wrap: 2 writes, 18 simultaneous cycles, 2 drain reads (20 words total)
        wr_idx = 0;
        for (int c = 0; c < 22; c++) begin
            WE = (c < 20);
            RE = (c >= 2);
            w  = 6'(wr_idx * 5 + 3);
            data_in = w;
            if (WE) begin
                exp_q.push_back(w);
                wr_idx++;
            end
            tick();
            if (RE) begin
                last_v = exp_q.pop_front();
                check($sformatf("wrap%0d", c), {2'b0, data_out}, {2'b0, last_v});
                $display("wrap cycle %0d data_out=0x%02h", c, data_out);
            end
        end
        WE = 1'b0; RE = 1'b0;
        check("wrap_empty", {7'b0, empty}, 8'h01);

        // Underflow: read while empty holds data_out
        RE = 1'b1;
        tick();
        RE = 1'b0;
        $display("empty read data_out=0x%02h empty=%0b", data_out, empty);
        check("uf_hold", {2'b0, data_out}, {2'b0, last_v});
        check("uf_empty", {7'b0, empty}, 8'h01);

        // Read and write while empty: read ignored, write lands
        WE = 1'b1; RE = 1'b1; data_in = 6'h2A;
        tick();
        WE = 1'b0; RE = 1'b0;
        $display("rdwr at empty data_out=0x%02h empty=%0b", data_out, empty);
        check("rwe_hold", {2'b0, data_out}, {2'b0, last_v});
        check("rwe_not_empty", {7'b0, empty}, 8'h00);
        pop_check("rwe_read", 6'h2A);
        check("rwe_empty", {7'b0, empty}, 8'h01);

        // Mid-operation asynchronous reset with 3 words held
        push(6'h31); push(6'h32); push(6'h33);
        pop_check("pre_rst", 6'h31);
        push(6'h34);
        #3;
        reset = 1'b0;
        #1;
        $display("async reset empty=%0b full=%0b data_out=0x%02h", empty, full, data_out);
        check("mid_empty", {7'b0, empty}, 8'h01);
        check("mid_dout", {2'b0, data_out}, 8'h00);
        check("mid_full", {7'b0, full}, 8'h00);
        WE = 1'b1; data_in = 6'h1E;
        tick();
        WE = 1'b0;
        check("mid_we_ignored", {7'b0, empty}, 8'h01);
        reset = 1'b1;
        tick();
        push(6'h05);
        pop_check("post_rst", 6'h05);
        check("post_rst_empty", {7'b0, empty}, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
